picc_sequence_encode: RTL and testbench

Transmit-side sequence encoder for PICC→PCD communication at 106 kbit/s. Consumes a stream of data bits over a valid/ready handshake and drives the load-modulator control line with ISO/IEC 14443-2 Type A Manchester coding on an fc/16 subcarrier. It frames each transmission with SOC (sequence D) and EOC (sequence F). It sits between the frame/CRC/parity generator and the analogue load modulator, and mirrors `sequence_decode` on the receive path.

---
 rtl/iso14443a_pkg.sv | 21 ++
 rtl/picc_sequence_encode_bit_timer.sv | 38 +++
 rtl/picc_sequence_encode.sv | 140 ++++++++++++++
 tb/tb_picc_sequence_encode.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iso14443a_pkg.sv
// ISO/IEC 14443 Type A shared definitions: bit-sequence codes, encoder FSM states and
// default 106 kbit/s timing constants.
package ISO14443A_pkg;

  localparam int unsigned BitCyclesDefault    = 128;
  localparam int unsigned ScHalfCyclesDefault = 8;

  typedef enum logic [1:0] {
    PICCBitSequence_D,
    PICCBitSequence_E,
    PICCBitSequence_F
  } PICCBitSequence;

  typedef enum logic [1:0] {
    StIdle,
    StSoc,
    StData,
    StEoc
  } enc_state_e;

endpackage

// File: rtl/picc_sequence_encode_bit_timer.sv
// Bit-period counter for the PICC sequence encoder: counts 0..BIT_CYCLES-1 while running,
// restarts on request and flags the last cycle of each period.
module picc_sequence_encode_bit_timer #(
  parameter int unsigned BIT_CYCLES = 128,
  parameter int unsigned CntW       = $clog2(BIT_CYCLES)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  input  logic            restart_i,
  output logic [CntW-1:0] cnt_o,
  output logic [CntW-1:0] cnt_next_o,
  output logic            wrap_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == CntW'(BIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || restart_i || wrap_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/picc_sequence_encode.sv
// PICC->PCD Type A Manchester sequence encoder (SOC, data D/E, EOC F) on an fc/16 subcarrier.
// Optional underrun pulse output enabled by defining PICC_SEQUENCE_ENCODE_UNDERRUN_EN.
module picc_sequence_encode
  import ISO14443A_pkg::*;
#(
  parameter int unsigned BIT_CYCLES     = BitCyclesDefault,
  parameter int unsigned SC_HALF_CYCLES = ScHalfCyclesDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_last,
  output logic in_ready,
  output logic lm_out,
  output logic idle
`ifdef PICC_SEQUENCE_ENCODE_UNDERRUN_EN
  ,
  output logic underrun
`endif
);

  localparam int unsigned CntW     = $clog2(BIT_CYCLES);
  localparam int unsigned ScPeriod = 2 * SC_HALF_CYCLES;
  localparam int unsigned HalfBit  = BIT_CYCLES / 2;

  enc_state_e      state_q, state_d;
  PICCBitSequence  seq_q, seq_d;
  logic            last_q, last_d;
  logic            lm_q, lm_d;
  logic [CntW-1:0] cnt_q, cnt_next;
  logic            wrap, sample;
  logic            sc_hi, first_half;

  picc_sequence_encode_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .CntW       (CntW)
  ) u_bit_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .run_i      (state_q != StIdle),
    .restart_i  (state_d != state_q),
    .cnt_o      (cnt_q),
    .cnt_next_o (cnt_next),
    .wrap_o     (wrap)
  );

  // A frame's last bit suppresses the sample point so EOC follows it directly.
  assign sample   = wrap && ((state_q == StSoc) || ((state_q == StData) && !last_q));
  assign in_ready = sample;
  assign idle     = (state_q == StIdle);
  assign lm_out   = lm_q;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StSoc;
          seq_d   = PICCBitSequence_D;
          last_d  = 1'b0;
        end
      end
      StSoc, StData: begin
        if (sample) begin
          if (in_valid) begin
            state_d = StData;
            seq_d   = in_data ? PICCBitSequence_D : PICCBitSequence_E;
            last_d  = in_last;
          end else begin
            state_d = StEoc;
            seq_d   = PICCBitSequence_F;
          end
        end else if (wrap) begin
          state_d = StEoc;
          seq_d   = PICCBitSequence_F;
        end
      end
      StEoc: begin
        if (wrap) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Modulator output is computed from next state/count so it lines up with period edges.
  always_comb begin
    sc_hi      = ((32'(cnt_next) % ScPeriod) < SC_HALF_CYCLES);
    first_half = (32'(cnt_next) < HalfBit);
    lm_d       = 1'b0;
    if (state_d != StIdle) begin
      case (seq_d)
        PICCBitSequence_D: lm_d = first_half && sc_hi;
        PICCBitSequence_E: lm_d = !first_half && sc_hi;
        default:           lm_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      seq_q   <= PICCBitSequence_F;
      last_q  <= 1'b0;
      lm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      last_q  <= last_d;
      lm_q    <= lm_d;
    end
  end

`ifdef PICC_SEQUENCE_ENCODE_UNDERRUN_EN
  logic underrun_q, underrun_d;

  assign underrun_d = sample && !in_valid;
  assign underrun   = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  a_underrun_eoc: assert property (@(posedge clk) disable iff (!rst_n)
    underrun_d |-> (state_d == StEoc));
`endif

  a_ready_at_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready |-> (cnt_q == CntW'(BIT_CYCLES - 1)));
  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    idle |-> !lm_out);

endmodule

// File: tb/tb_picc_sequence_encode.sv
// Directed bench for picc_sequence_encode: waveform checkpoints, Manchester decode of whole
// frames, underrun truncation, back-to-back framing and asynchronous reset.
module tb_picc_sequence_encode;

  localparam int TrLen = 1600;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_data, in_last;
  logic in_ready, lm_out, idle;
`ifdef PICC_SEQUENCE_ENCODE_UNDERRUN_EN
  logic underrun;
`endif

  picc_sequence_encode dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .lm_out   (lm_out),
    .idle     (idle)
`ifdef PICC_SEQUENCE_ENCODE_UNDERRUN_EN
    ,
    .underrun (underrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic lm_tr  [TrLen];
  logic idle_tr[TrLen];
  logic rdy_tr [TrLen];
  logic ur_tr  [TrLen];
  bit   fb     [16];
  int   accepted;

  typedef struct {
    int off;
    bit lm;
    bit idl;
    bit rdy;
  } point_t;

  point_t pts[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives a frame starting at the current cycle (T = trace index 0) and records outputs.
  task automatic run(input int nbits, input int withhold, input bit rearm, input int ncyc);
    int  idx;
    bit  take;
    idx      = 0;
    accepted = 0;
    in_valid = 1'b1;
    in_data  = fb[0];
    in_last  = (nbits == 1);
    for (int c = 0; c < ncyc; c++) begin
      lm_tr[c]   = lm_out;
      idle_tr[c] = idle;
      rdy_tr[c]  = in_ready;
`ifdef PICC_SEQUENCE_ENCODE_UNDERRUN_EN
      ur_tr[c]   = underrun;
`else
      ur_tr[c]   = 1'b0;
`endif
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (take) begin
        accepted++;
        idx++;
        if (idx < nbits && idx != withhold) begin
          in_data = fb[idx];
          in_last = (idx == nbits - 1);
        end else if (rearm) begin
          in_valid = 1'b1;
          in_data  = 1'b1;
          in_last  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  endtask

  // 0 = D, 1 = E, 2 = F, 3 = not a valid sequence
  function automatic int decode(input int base);
    bit   f_mod, f_zero, s_mod, s_zero;
    logic pat;
    f_mod = 1; f_zero = 1; s_mod = 1; s_zero = 1;
    for (int i = 0; i < 64; i++) begin
      pat = ((i % 16) < 8);
      if (lm_tr[base + i] !== pat) f_mod = 0;
      if (lm_tr[base + i] !== 1'b0) f_zero = 0;
      if (lm_tr[base + 64 + i] !== pat) s_mod = 0;
      if (lm_tr[base + 64 + i] !== 1'b0) s_zero = 0;
    end
    if (f_mod && s_zero) return 0;
    if (f_zero && s_mod) return 1;
    if (f_zero && s_zero) return 2;
    return 3;
  endfunction

  function automatic int count_rdy(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (rdy_tr[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic reset_release();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int exp_frame[10];
  int cnt_hi;
  int nur;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0;
    pts[0]  = '{0,   0, 1, 0};  pts[1]  = '{1,   1, 0, 0};  pts[2]  = '{8,   1, 0, 0};
    pts[3]  = '{9,   0, 0, 0};  pts[4]  = '{17,  1, 0, 0};  pts[5]  = '{49,  1, 0, 0};
    pts[6]  = '{57,  0, 0, 0};  pts[7]  = '{64,  0, 0, 0};  pts[8]  = '{65,  0, 0, 0};
    pts[9]  = '{127, 0, 0, 0};  pts[10] = '{128, 0, 0, 1};  pts[11] = '{129, 1, 0, 0};
    pts[12] = '{136, 1, 0, 0};  pts[13] = '{137, 0, 0, 0};  pts[14] = '{192, 0, 0, 0};
    pts[15] = '{193, 0, 0, 0};  pts[16] = '{256, 0, 0, 0};  pts[17] = '{257, 0, 0, 0};
    pts[18] = '{320, 0, 0, 0};  pts[19] = '{384, 0, 0, 0};  pts[20] = '{385, 0, 1, 0};
    pts[21] = '{386, 0, 1, 0};

    #22;
    chk("reset_lm", lm_out, 0);
    chk("reset_idle", idle, 1);
    chk("reset_ready", in_ready, 0);
`ifdef PICC_SEQUENCE_ENCODE_UNDERRUN_EN
    chk("reset_underrun", underrun, 0);
`endif
    reset_release();
    repeat (2) @(posedge clk);
    #1;

    // Single bit 1, last
    fb[0] = 1'b1;
    run(1, -1, 1'b0, 390);
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("single_lm@%0d", pts[i].off), lm_tr[pts[i].off], pts[i].lm);
      chk($sformatf("single_idle@%0d", pts[i].off), idle_tr[pts[i].off], pts[i].idl);
      chk($sformatf("single_rdy@%0d", pts[i].off), rdy_tr[pts[i].off], pts[i].rdy);
    end
    cnt_hi = 0;
    for (int i = 0; i < 390; i++) if (lm_tr[i] === 1'b1) cnt_hi++;
    chk("single_lm_high_cycles", cnt_hi, 64);
    chk("single_ready_count", count_rdy(0, 389), 1);
    chk("single_accepted", accepted, 1);

    // Frame 1,0,1,1,0,0,0,1
    fb[0] = 1; fb[1] = 0; fb[2] = 1; fb[3] = 1; fb[4] = 0; fb[5] = 0; fb[6] = 0; fb[7] = 1;
    exp_frame = '{0, 0, 1, 0, 0, 1, 1, 1, 0, 2};
    run(8, -1, 1'b0, 1290);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("frame_period%0d", k), decode(1 + 128 * k), exp_frame[k]);
    end
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("frame_ready@%0d", 128 * (j + 1)), rdy_tr[128 * (j + 1)], 1);
    end
    chk("frame_ready_count", count_rdy(0, 1289), 8);
    chk("frame_accepted", accepted, 8);
    chk("frame_busy_end", idle_tr[1280], 0);
    chk("frame_idle_after", idle_tr[1281], 1);

    // Underrun at the third sample point
    fb[0] = 1; fb[1] = 0; fb[2] = 1;
    run(8, 2, 1'b0, 520);
    chk("ur_period0", decode(1), 0);
    chk("ur_period1", decode(129), 0);
    chk("ur_period2", decode(257), 1);
    chk("ur_period3", decode(385), 2);
    chk("ur_accepted", accepted, 2);
    chk("ur_busy_end", idle_tr[512], 0);
    chk("ur_idle_after", idle_tr[513], 1);
`ifdef PICC_SEQUENCE_ENCODE_UNDERRUN_EN
    nur = 0;
    for (int i = 0; i < 520; i++) if (ur_tr[i] === 1'b1) nur++;
    chk("ur_pulse_count", nur, 1);
    chk("ur_pulse_at_eoc", ur_tr[385], 1);
`endif

    // in_valid held across EOC into IDLE
    fb[0] = 1'b1;
    run(1, -1, 1'b1, 400);
    chk("rearm_accepted", accepted, 1);
    chk("rearm_no_ready_eoc", count_rdy(129, 399), 0);
    chk("rearm_eoc_busy", idle_tr[384], 0);
    chk("rearm_idle_gap", idle_tr[385], 1);
    chk("rearm_gap_lm", lm_tr[385], 0);
    chk("rearm_new_soc_idle", idle_tr[386], 0);
    chk("rearm_new_soc_lm", lm_tr[386], 1);
    in_valid = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("rearm_drained", idle, 1);

    // Reset mid-DATA at cnt=40
    fb[0] = 1; fb[1] = 0; fb[2] = 1; fb[3] = 1; fb[4] = 0; fb[5] = 0; fb[6] = 0; fb[7] = 1;
    run(8, -1, 1'b0, 169);
    chk("rst_pre_busy", idle, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_lm", lm_out, 0);
    chk("rst_mid_idle", idle, 1);
    chk("rst_mid_ready", in_ready, 0);
    reset_release();
    fb[0] = 1'b1;
    run(1, -1, 1'b0, 390);
    chk("rst_new_soc_lm", lm_tr[1], 1);
    chk("rst_new_soc", decode(1), 0);
    chk("rst_new_bit", decode(129), 0);
    chk("rst_new_eoc", decode(257), 2);
    chk("rst_new_idle", idle_tr[385], 1);

    // Reset while the subcarrier is high must clear lm_out without a clock edge
    run(1, -1, 1'b0, 3);
    chk("rst_async_pre_lm", lm_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_lm", lm_out, 0);
    chk("rst_async_idle", idle, 1);
    reset_release();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
